// File: rtl/zx_video_capture.sv
// ZX Spectrum RGBI capture front-end: sync filtering, line/frame tracking, pixel packing and lock detection.
// Optional build macro CAP_GATE_LOCK_EN suppresses SRAM write strobes while line timing is unlocked.
module zx_video_capture #(
    parameter int H_OFFSET   = 64,
    parameter int H_ACTIVE   = 512,
    parameter int SYNC_FILT  = 3,
    parameter int LINE_MIN   = 880,
    parameter int LINE_MAX   = 912,
    parameter int LOCK_LINES = 16
) (
    input  logic        pix_clk,
    input  logic        rst_n,
    input  logic        zx_r,
    input  logic        zx_g,
    input  logic        zx_b,
    input  logic        zx_i,
    input  logic        zx_hsync,
    input  logic        zx_vsync,
    output logic        wr_en,
    output logic [16:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic [9:0]  line_len
);

    localparam logic [10:0] H_BEG_C    = 11'(H_OFFSET);
    localparam logic [10:0] H_END_C    = 11'(H_OFFSET + H_ACTIVE);
    localparam logic [8:0]  H_OFF9_C   = 9'(H_OFFSET);
    localparam logic [2:0]  FILT_C     = 3'(SYNC_FILT - 1);
    localparam logic [9:0]  LINE_MIN_C = 10'(LINE_MIN);
    localparam logic [9:0]  LINE_MAX_C = 10'(LINE_MAX);
    localparam logic [7:0]  LOCK_C     = 8'(LOCK_LINES);
    localparam logic [9:0]  H_SAT_C    = 10'd1023;
    localparam logic [8:0]  V_SAT_C    = 9'd511;
`ifdef CAP_GATE_LOCK_EN
    localparam logic        GATE_C     = 1'b1;
`else
    localparam logic        GATE_C     = 1'b0;
`endif

    // Sync path state (idle high)
    logic       hs_meta_q, hs_sync_q, hs_filt_q, hs_filt_d, hs_hist_q;
    logic       vs_meta_q, vs_sync_q, vs_filt_q, vs_filt_d, vs_hist_q;
    logic [2:0] hs_fcnt_q, hs_fcnt_d, vs_fcnt_q, vs_fcnt_d;
    logic       hs_fall_s, vs_fall_s;

    // Timing / capture state
    logic [3:0]  rgbi_q, lo_q, lo_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [8:0]  v_cnt_q, v_cnt_d;
    logic        vs_pend_q, vs_pend_d;
    logic [7:0]  good_cnt_q, good_cnt_d, good_next_s;
    logic        seen_q, seen_d;
    logic        wr_en_q, wr_en_d;
    logic [16:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic [9:0]  line_len_q, line_len_d;
    logic [9:0]  len_s;
    logic [8:0]  pix_s;
    logic        in_win_s;

    // Synchronizers, filtered levels and edge history
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_meta_q <= 1'b1;
            hs_sync_q <= 1'b1;
            hs_filt_q <= 1'b1;
            hs_hist_q <= 1'b1;
            hs_fcnt_q <= 3'd0;
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_filt_q <= 1'b1;
            vs_hist_q <= 1'b1;
            vs_fcnt_q <= 3'd0;
            rgbi_q    <= 4'd0;
        end else begin
            hs_meta_q <= zx_hsync;
            hs_sync_q <= hs_meta_q;
            hs_filt_q <= hs_filt_d;
            hs_hist_q <= hs_filt_q;
            hs_fcnt_q <= hs_fcnt_d;
            vs_meta_q <= zx_vsync;
            vs_sync_q <= vs_meta_q;
            vs_filt_q <= vs_filt_d;
            vs_hist_q <= vs_filt_q;
            vs_fcnt_q <= vs_fcnt_d;
            rgbi_q    <= {zx_r, zx_g, zx_b, zx_i};
        end
    end

    // Glitch filter: level follows only after SYNC_FILT consecutive differing samples
    always_comb begin
        hs_filt_d = hs_filt_q;
        hs_fcnt_d = 3'd0;
        vs_filt_d = vs_filt_q;
        vs_fcnt_d = 3'd0;
        if (hs_sync_q != hs_filt_q) begin
            if (hs_fcnt_q == FILT_C) begin
                hs_filt_d = hs_sync_q;
            end else begin
                hs_fcnt_d = hs_fcnt_q + 3'd1;
            end
        end else begin
            hs_fcnt_d = 3'd0;
        end
        if (vs_sync_q != vs_filt_q) begin
            if (vs_fcnt_q == FILT_C) begin
                vs_filt_d = vs_sync_q;
            end else begin
                vs_fcnt_d = vs_fcnt_q + 3'd1;
            end
        end else begin
            vs_fcnt_d = 3'd0;
        end
    end

    assign hs_fall_s = hs_hist_q & ~hs_filt_q;
    assign vs_fall_s = vs_hist_q & ~vs_filt_q;

    // Line/frame counters, pixel packing and lock tracking
    always_comb begin
        h_cnt_d       = (h_cnt_q == H_SAT_C) ? h_cnt_q : h_cnt_q + 10'd1;
        v_cnt_d       = v_cnt_q;
        vs_pend_d     = vs_pend_q;
        good_cnt_d    = good_cnt_q;
        seen_d        = seen_q;
        lo_d          = lo_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        locked_d      = locked_q;
        line_len_d    = line_len_q;
        len_s         = (h_cnt_q == H_SAT_C) ? H_SAT_C : h_cnt_q + 10'd1;
        good_next_s   = (good_cnt_q >= LOCK_C) ? LOCK_C : good_cnt_q + 8'd1;
        pix_s         = h_cnt_q[8:0] - H_OFF9_C;
        in_win_s      = ({1'b0, h_cnt_q} >= H_BEG_C) && ({1'b0, h_cnt_q} < H_END_C);

        if (hs_fall_s) begin
            h_cnt_d      = 10'd0;
            line_start_d = 1'b1;
            seen_d       = 1'b1;
            if (vs_pend_q || vs_fall_s) begin
                v_cnt_d       = 9'd0;
                vs_pend_d     = 1'b0;
                frame_start_d = 1'b1;
            end else begin
                v_cnt_d = (v_cnt_q == V_SAT_C) ? v_cnt_q : v_cnt_q + 9'd1;
            end
            // The stretch before the first edge after reset is not a real line.
            if (seen_q) begin
                line_len_d = len_s;
                if ((len_s >= LINE_MIN_C) && (len_s <= LINE_MAX_C)) begin
                    good_cnt_d = good_next_s;
                    locked_d   = (good_next_s == LOCK_C);
                end else begin
                    good_cnt_d = 8'd0;
                    locked_d   = 1'b0;
                end
            end else begin
                line_len_d = line_len_q;
            end
        end else begin
            if (vs_fall_s) begin
                vs_pend_d = 1'b1;
            end else begin
                vs_pend_d = vs_pend_q;
            end
            if (h_cnt_d == H_SAT_C) begin
                good_cnt_d = 8'd0;
                locked_d   = 1'b0;
            end else begin
                good_cnt_d = good_cnt_q;
            end
            if (seen_q && in_win_s) begin
                if (!pix_s[0]) begin
                    lo_d = rgbi_q;
                end else begin
                    wr_en_d   = ~GATE_C | locked_q;
                    wr_data_d = {rgbi_q, lo_q};
                    wr_addr_d = {v_cnt_q, pix_s[8:1]};
                end
            end else begin
                lo_d = lo_q;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 9'd0;
            vs_pend_q     <= 1'b0;
            good_cnt_q    <= 8'd0;
            seen_q        <= 1'b0;
            lo_q          <= 4'd0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 17'd0;
            wr_data_q     <= 8'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            line_len_q    <= 10'd0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            vs_pend_q     <= vs_pend_d;
            good_cnt_q    <= good_cnt_d;
            seen_q        <= seen_d;
            lo_q          <= lo_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            line_len_q    <= line_len_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign line_len    = line_len_q;

endmodule

// File: tb/tb_zx_video_capture.sv
// Directed bench for zx_video_capture: nominal lines, packing, glitch, vsync, lock loss and reset.
module tb_zx_video_capture;

    logic        pix_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        zx_r = 1'b0, zx_g = 1'b0, zx_b = 1'b0, zx_i = 1'b0;
    logic        zx_hsync = 1'b1;
    logic        zx_vsync = 1'b1;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        line_start;
    logic        frame_start;
    logic        locked;
    logic [9:0]  line_len;

    zx_video_capture dut (
        .pix_clk(pix_clk), .rst_n(rst_n),
        .zx_r(zx_r), .zx_g(zx_g), .zx_b(zx_b), .zx_i(zx_i),
        .zx_hsync(zx_hsync), .zx_vsync(zx_vsync),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .line_start(line_start), .frame_start(frame_start),
        .locked(locked), .line_len(line_len)
    );

    always #5 pix_clk = ~pix_clk;

    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    int hc = 0, ls_cnt = 0, fs_cnt = 0, fs_bad = 0, data_bad = 0;
    int wr_line = 0, first_hc = -1, last_hc = -1, drop_hc = -1;
    int ls_before, fs_before, exp_wr_unlocked;
    logic [16:0] first_addr = 17'd0, last_addr = 17'd0;
    logic        locked_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs just after the edge, then drive the next pixel.
    task automatic tick();
        @(posedge pix_clk);
        #1;
        if (line_start === 1'b1) begin
            hc = 0; ls_cnt++; wr_line = 0; first_hc = -1; last_hc = -1;
        end else if (hc < 4000) begin
            hc++;
        end
        if (frame_start === 1'b1) begin
            fs_cnt++;
            if (line_start !== 1'b1) fs_bad++;
        end
        if (wr_en === 1'b1) begin
            if (first_hc < 0) begin first_hc = hc; first_addr = wr_addr; end
            last_hc = hc; last_addr = wr_addr; wr_line++;
            if (wr_data !== 8'hC3) data_bad++;
        end
        if (locked_prev === 1'b1 && locked === 1'b0) drop_hc = hc;
        locked_prev = locked;
        {zx_r, zx_g, zx_b, zx_i} = ((hc + 1) % 2 == 0) ? 4'h3 : 4'hC;
    endtask

    task automatic hline(input int len, input int low, input int vs_at, input int vs_len, input int gl_at);
        for (int i = 0; i < len; i++) begin
            zx_hsync = ((i < low) || (gl_at >= 0 && i >= gl_at && i < gl_at + 2)) ? 1'b0 : 1'b1;
            zx_vsync = (vs_at >= 0 && i >= vs_at && i < vs_at + vs_len) ? 1'b0 : 1'b1;
            tick();
        end
    endtask

    initial begin
`ifdef CAP_GATE_LOCK_EN
        exp_wr_unlocked = 0;
`else
        exp_wr_unlocked = 256;
`endif
        // Reset state
        for (int i = 0; i < 4; i++) tick();
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {15'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_line_start", {31'd0, line_start}, 32'd0);
        check("rst_frame_start", {31'd0, frame_start}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_line_len", {22'd0, line_len}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        // First line after reset: no length measured yet
        hline(896, 64, -1, 0, -1);
        check("l1_line_len", {22'd0, line_len}, 32'd0);
        check("l1_writes", wr_line, exp_wr_unlocked);
        check("l1_locked", {31'd0, locked}, 32'd0);
        for (int i = 0; i < 15; i++) hline(896, 64, -1, 0, -1);
        check("l16_locked", {31'd0, locked}, 32'd0);
        check("l16_line_len", {22'd0, line_len}, 32'd896);
        hline(896, 64, -1, 0, -1);
        check("l17_locked", {31'd0, locked}, 32'd1);
        check("l17_writes", wr_line, 32'd256);
        check("l17_first_hc", first_hc, 32'd66);
        check("l17_last_hc", last_hc, 32'd576);
        check("l17_first_addr", {15'd0, first_addr}, {15'd0, 9'd17, 8'h00});
        check("l17_last_addr", {15'd0, last_addr}, {15'd0, 9'd17, 8'hFF});
        check("l17_data_c3", data_bad, 32'd0);
        check("l17_no_frame", fs_cnt, 32'd0);

        // Two-clock hsync glitch mid-line
        ls_before = ls_cnt;
        hline(896, 64, -1, 0, 400);
        check("glitch_ls", ls_cnt, ls_before + 1);
        check("glitch_writes", wr_line, 32'd256);
        check("glitch_locked", {31'd0, locked}, 32'd1);

        // Vsync mid-line: frame_start only at the following line_start
        fs_before = fs_cnt;
        hline(896, 64, 300, 200, -1);
        check("vs_mid_no_fs", fs_cnt, fs_before);
        check("vs_mid_v", {23'd0, first_addr[16:8]}, 32'd19);
        hline(896, 64, -1, 0, -1);
        check("vs_next_fs", fs_cnt, fs_before + 1);
        check("vs_next_v", {23'd0, first_addr[16:8]}, 32'd0);
        check("vs_after_glitch_len", {22'd0, line_len}, 32'd896);
        check("vs_locked", {31'd0, locked}, 32'd1);
        // Simultaneous H and V edges
        hline(896, 64, 0, 200, -1);
        check("vs_sim_fs", fs_cnt, fs_before + 2);
        check("vs_sim_v", {23'd0, first_addr[16:8]}, 32'd0);
        hline(896, 64, -1, 0, -1);
        check("vs_after_fs", fs_cnt, fs_before + 2);
        check("vs_after_v", {23'd0, first_addr[16:8]}, 32'd1);
        check("fs_aligned", fs_bad, 32'd0);

        // Short line breaks lock
        hline(700, 64, -1, 0, -1);
        hline(896, 64, -1, 0, -1);
        check("short_len", {22'd0, line_len}, 32'd700);
        check("short_locked", {31'd0, locked}, 32'd0);
        check("short_writes", wr_line, exp_wr_unlocked);
        for (int i = 0; i < 15; i++) hline(896, 64, -1, 0, -1);
        check("relock_15", {31'd0, locked}, 32'd0);
        hline(896, 64, -1, 0, -1);
        check("relock_16", {31'd0, locked}, 32'd1);

        // Hsync removed: lock drops when h_cnt saturates
        drop_hc   = -1;
        ls_before = ls_cnt;
        zx_hsync  = 1'b1;
        for (int i = 0; i < 1100; i++) tick();
        check("loss_drop_hc", drop_hc, 32'd1023);
        check("loss_locked", {31'd0, locked}, 32'd0);
        check("loss_no_ls", ls_cnt, ls_before);
        hline(896, 64, -1, 0, -1);
        check("loss_len_sat", {22'd0, line_len}, 32'd1023);
        check("loss_locked2", {31'd0, locked}, 32'd0);

        // Asynchronous reset mid-capture
        zx_hsync = 1'b0;
        for (int i = 0; i < 64; i++) tick();
        zx_hsync = 1'b1;
        for (int i = 0; i < 150; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_addr", {15'd0, wr_addr}, 32'd0);
        check("mid_rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("mid_rst_line_len", {22'd0, line_len}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        rst_n   = 1'b1;
        wr_line = 0;
        for (int i = 0; i < 700; i++) tick();
        check("post_rst_no_wr", wr_line, 32'd0);
        hline(896, 64, -1, 0, -1);
        check("post_rst_writes", wr_line, exp_wr_unlocked);
        check("post_rst_len0", {22'd0, line_len}, 32'd0);
        hline(896, 64, -1, 0, -1);
        check("post_rst_len", {22'd0, line_len}, 32'd896);
        check("post_rst_locked", {31'd0, locked}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
